// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM-state encodings, plus the memory arbiter's
// state and grant types and its arbitration helper.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // RAM bus status as reported by the RAM controller
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter states: arbitration, service of one requester, one-cycle hit
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DSVC   = 3'd1,
        ISVC   = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } arb_state_t;

    // Which requester completed most recently
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Choose the service state from IDLE. Under contention the requester that
    // did not complete last wins, so neither side can starve the other.
    function automatic arb_state_t arb_pick(input logic d_req, input logic i_req,
                                            input grant_t last_grant);
        arb_state_t nxt;
        nxt = IDLE;
        if (d_req && i_req) begin
            if (last_grant == GRANT_I) nxt = DSVC;
            else                       nxt = ISVC;
        end else if (d_req) begin
            nxt = DSVC;
        end else if (i_req) begin
            nxt = ISVC;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Service watchdog for mem_hit_arbiter: counts cycles spent in a service
// state and flags expiry in the TIMEOUT_CYCLES-th cycle of that service.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_expired
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (CNT_BITS < 8) ? 8 : CNT_BITS;

    logic [CNT_W-1:0] r_cnt;

    // Count while a service is active; leaving service clears the count so
    // each new service starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_active) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_expired = i_active && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_hit_arbiter.sv
// mem_hit_arbiter: responder side of the ihit/dhit pipeline handshake.
// Arbitrates instruction fetches and data accesses onto the single-ported
// RAM bus, returns registered load data and a one-cycle hit pulse.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a service watchdog that
// aborts a service after TIMEOUT_CYCLES cycles and pulses arb_err.
module mem_hit_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction side
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    // data side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    // RAM bus
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    // status
    output logic              arb_err
);

    arb_state_t        r_state;
    grant_t            r_last_grant;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic              r_ihit;
    logic              r_dhit;
    logic              r_arb_err;

    logic              w_d_req;
    logic              w_in_svc;
    logic              w_timeout;
    logic              w_ram_ren;
    logic              w_ram_wen;
    logic [DATA_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_store;

    assign w_d_req  = dREN || dWEN;
    assign w_in_svc = (r_state == DSVC) || (r_state == ISVC);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (CLK),
        .rst       (RST),
        .i_active  (w_in_svc),
        .o_expired (w_timeout)
    );
`else
    // Without the watchdog a service waits on the RAM indefinitely; the
    // limit is accepted but has no effect.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // RAM bus drive: strobes, address and store data only in a service state,
    // following the granted requester's inputs combinationally.
    always_comb begin
        w_ram_ren   = 1'b0;
        w_ram_wen   = 1'b0;
        w_ram_addr  = '0;
        w_ram_store = '0;
        case (r_state)
            DSVC: begin
                w_ram_addr = daddr;
                if (dWEN) begin
                    w_ram_wen   = 1'b1;
                    w_ram_store = dstore;
                end else begin
                    w_ram_ren = dREN;
                end
            end
            ISVC: begin
                w_ram_addr = iaddr;
                w_ram_ren  = iREN;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered hit/error pulses and load capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_iload      <= '0;
            r_dload      <= '0;
            r_ihit       <= 1'b0;
            r_dhit       <= 1'b0;
            r_arb_err    <= 1'b0;
        end else begin
            r_ihit    <= 1'b0;
            r_dhit    <= 1'b0;
            r_arb_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= arb_pick(w_d_req, iREN, r_last_grant);
                end
                DSVC: begin
                    if (!w_d_req) begin
                        r_state <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        if (!dWEN) r_dload <= ramload;
                        r_dhit       <= 1'b1;
                        r_last_grant <= GRANT_D;
                        r_state      <= DONE_D;
                    end else if ((ramstate == ERROR) || w_timeout) begin
                        r_arb_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                ISVC: begin
                    if (!iREN) begin
                        r_state <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        r_iload      <= ramload;
                        r_ihit       <= 1'b1;
                        r_last_grant <= GRANT_I;
                        r_state      <= DONE_I;
                    end else if ((ramstate == ERROR) || w_timeout) begin
                        r_arb_err <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                DONE_D, DONE_I: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ramREN   = w_ram_ren;
    assign ramWEN   = w_ram_wen;
    assign ramaddr  = w_ram_addr;
    assign ramstore = w_ram_store;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign arb_err  = r_arb_err;

endmodule

// File: tb/tb_mem_hit_arbiter.sv
// Self-checking bench for mem_hit_arbiter. A behavioural RAM answers the bus
// with a programmable number of BUSY cycles (or stuck BUSY / ERROR); the
// expected grant order, latency and data come from a reference model of the
// arbitration rules and a reference copy of memory contents.
module tb_mem_hit_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload;
    logic        ihit, dhit;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] ramload  = '0;
    ramstate_t   ramstate = FREE;
    logic        arb_err;

    int checks = 0;
    int errors = 0;

    // RAM model state and reference memory
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    int          ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR
    int          ram_wait = 0;   // BUSY cycles before ACCESS
    int          busy_cnt = 0;

    // Reference model state
    bit          last_was_d;
    logic [31:0] exp_iload, exp_dload;

    mem_hit_arbiter #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .arb_err  (arb_err)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM: reacts to strobes seen mid-cycle, presents its status
    // for the next rising edge. Load data is garbage except during ACCESS.
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            ramload = $urandom;
            if (ram_mode == 1) begin
                ramstate = BUSY;
            end else if (ram_mode == 2) begin
                ramstate = ERROR;
            end else if (busy_cnt >= ram_wait) begin
                ramstate = ACCESS;
                if (ramWEN) mem[ramaddr[7:2]] = ramstore;
                else        ramload = mem[ramaddr[7:2]];
            end else begin
                ramstate = BUSY;
            end
            busy_cnt++;
        end else begin
            ramstate = FREE;
            ramload  = $urandom;
            busy_cnt = 0;
        end
    end

    // Wait (bounded) for a hit; ncyc = limit+1 means none arrived.
    task automatic wait_hit(input int limit, output bit got_i, output bit got_d,
                            output int ncyc);
        got_i = 1'b0;
        got_d = 1'b0;
        ncyc  = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge CLK);
            if (ihit === 1'b1 || dhit === 1'b1) begin
                got_i = ihit;
                got_d = dhit;
                ncyc  = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (2) @(negedge CLK);
        if ({ihit, dhit, ramREN, ramWEN, arb_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, ramREN, ramWEN, arb_err});
        end
        checks++;
        if ({iload, dload, ramaddr, ramstore} !== 128'b0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", {iload, dload, ramaddr, ramstore});
        end
        checks++;
        RST = 1'b0;
        @(negedge CLK);
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", {ramREN, ramWEN, ihit, dhit});
        end
        checks++;
        last_was_d = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_ifetch();
        ram_mode = 0; ram_wait = 1;
        iREN = 1'b1; iaddr = 32'h0000_0040;
        @(negedge CLK);
        if ({ramREN, ramWEN, ihit} !== 3'b100 || ramaddr !== 32'h40) begin
            errors++;
            $display("FAIL t1_strobe: got ren/wen/hit=%b addr=%h expected 100 addr=00000040",
                     {ramREN, ramWEN, ihit}, ramaddr);
        end
        checks++;
        @(negedge CLK);
        if (ihit !== 1'b0) begin
            errors++; $display("FAIL t1_early_hit: got %b expected 0", ihit);
        end
        checks++;
        @(negedge CLK);
        if (ihit !== 1'b1 || dhit !== 1'b0) begin
            errors++; $display("FAIL t1_ihit: got i=%b d=%b expected i=1 d=0", ihit, dhit);
        end
        checks++;
        if (iload !== 32'h2108_0001) begin
            errors++; $display("FAIL t1_iload: got %h expected 21080001", iload);
        end
        checks++;
        exp_iload = 32'h2108_0001;
        iREN = 1'b0;
        last_was_d = 1'b0;
        @(negedge CLK);
        if (ihit !== 1'b0 || ramREN !== 1'b0 || iload !== exp_iload) begin
            errors++;
            $display("FAIL t1_after: got hit=%b ren=%b iload=%h expected 0 0 %h", ihit, ramREN, iload, exp_iload);
        end
        checks++;
        $display("txn I addr=00000040 data=%h", iload);
    endtask

    task automatic test_priority();
        bit gi, gd;
        int n;
        ram_mode = 0; ram_wait = 0;
        iREN = 1'b1; iaddr = 32'h44;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        @(negedge CLK);
        if ({ramWEN, ramREN, ihit, dhit} !== 4'b1000 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL t2_dwrite: got wen/ren/ih/dh=%b addr=%h store=%h expected 1000 00000080 deadbeef",
                     {ramWEN, ramREN, ihit, dhit}, ramaddr, ramstore);
        end
        checks++;
        @(negedge CLK);
        if (dhit !== 1'b1 || ihit !== 1'b0) begin
            errors++; $display("FAIL t2_dhit: got d=%b i=%b expected d=1 i=0", dhit, ihit);
        end
        checks++;
        ref_mem[32] = 32'hDEAD_BEEF;
        if (mem[32] !== ref_mem[32]) begin
            errors++; $display("FAIL t2_ramdata: got %h expected %h", mem[32], ref_mem[32]);
        end
        checks++;
        dWEN = 1'b0;
        last_was_d = 1'b1;
        $display("txn D write addr=00000080 data=deadbeef");
        @(negedge CLK);
        if ({ihit, dhit} !== 2'b00) begin
            errors++; $display("FAIL t2_gap: got %b expected 00", {ihit, dhit});
        end
        checks++;
        wait_hit(20, gi, gd, n);
        if ({gi, gd} !== 2'b10 || n != 2) begin
            errors++; $display("FAIL t2_ihit: got i/d=%b lat=%0d expected 10 lat=2", {gi, gd}, n);
        end
        checks++;
        exp_iload = ref_mem[17];
        if (iload !== exp_iload) begin
            errors++; $display("FAIL t2_iload: got %h expected %h", iload, exp_iload);
        end
        checks++;
        iREN = 1'b0;
        last_was_d = 1'b0;
        $display("txn I addr=00000044 data=%h", iload);
        @(negedge CLK);
    endtask

    task automatic test_alternate();
        bit gi, gd, exp_d;
        int n, lat;
        ram_mode = 0; ram_wait = $urandom_range(0, 2);
        iaddr = 32'($urandom_range(0, 63) * 4);
        daddr = 32'($urandom_range(0, 63) * 4);
        iREN = 1'b1; dREN = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = !last_was_d;
            lat = 2 + ram_wait;
            wait_hit(20, gi, gd, n);
            if ({gi, gd} !== {!exp_d, exp_d} || n != lat) begin
                errors++;
                $display("FAIL t3_grant%0d: got i/d=%b lat=%0d expected %b lat=%0d", t, {gi, gd}, n, {!exp_d, exp_d}, lat);
            end
            checks++;
            if (exp_d) begin
                exp_dload = ref_mem[daddr[7:2]];
                if (dload !== exp_dload) begin
                    errors++; $display("FAIL t3_dload%0d: got %h expected %h", t, dload, exp_dload);
                end
                $display("txn D read addr=%h data=%h", daddr, dload);
                daddr = 32'($urandom_range(0, 63) * 4);
            end else begin
                exp_iload = ref_mem[iaddr[7:2]];
                if (iload !== exp_iload) begin
                    errors++; $display("FAIL t3_iload%0d: got %h expected %h", t, iload, exp_iload);
                end
                $display("txn I addr=%h data=%h", iaddr, iload);
                iaddr = 32'($urandom_range(0, 63) * 4);
            end
            checks++;
            last_was_d = exp_d;
            ram_wait = $urandom_range(0, 2);
            if (t == 3) begin
                iREN = 1'b0; dREN = 1'b0;
            end
            @(negedge CLK);
            if ({ihit, dhit} !== 2'b00) begin
                errors++; $display("FAIL t3_pulse%0d: got %b expected 00", t, {ihit, dhit});
            end
            checks++;
        end
    endtask

    task automatic test_abort_error();
        bit gi, gd;
        int n;
        logic [31:0] held_dload;
        held_dload = dload;
        ram_mode = 1;
        dREN = 1'b1; daddr = 32'($urandom_range(0, 63) * 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (ramREN !== 1'b1 || dhit !== 1'b0) begin
                errors++; $display("FAIL t4_busy%0d: got ren=%b dhit=%b expected 1 0", c, ramREN, dhit);
            end
            checks++;
        end
        dREN = 1'b0;
        @(negedge CLK);
        if ({ramREN, ramWEN, dhit, arb_err} !== 4'b0 || dload !== held_dload) begin
            errors++;
            $display("FAIL t4_abort: got ren/wen/dhit/err=%b dload=%h expected 0000 %h",
                     {ramREN, ramWEN, dhit, arb_err}, dload, held_dload);
        end
        checks++;
        $display("txn D abort addr=%h", daddr);
        ram_mode = 2;
        iREN = 1'b1; iaddr = 32'($urandom_range(0, 63) * 4);
        @(negedge CLK);
        if (ramREN !== 1'b1) begin
            errors++; $display("FAIL t4_isvc: got ren=%b expected 1", ramREN);
        end
        checks++;
        @(negedge CLK);
        if (arb_err !== 1'b1 || ihit !== 1'b0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL t4_error: got err=%b ihit=%b ren=%b expected 1 0 0", arb_err, ihit, ramREN);
        end
        checks++;
        iREN = 1'b0;
        @(negedge CLK);
        if (arb_err !== 1'b0 || ihit !== 1'b0) begin
            errors++; $display("FAIL t4_err_pulse: got err=%b ihit=%b expected 0 0", arb_err, ihit);
        end
        checks++;
        $display("txn I error addr=%h", iaddr);
        ram_mode = 0; ram_wait = 1;
        iREN = 1'b1;
        wait_hit(20, gi, gd, n);
        exp_iload = ref_mem[iaddr[7:2]];
        if ({gi, gd} !== 2'b10 || n != 3 || iload !== exp_iload) begin
            errors++;
            $display("FAIL t4_retry: got i/d=%b lat=%0d iload=%h expected 10 lat=3 %h", {gi, gd}, n, iload, exp_iload);
        end
        checks++;
        iREN = 1'b0;
        last_was_d = 1'b0;
        $display("txn I retry addr=%h data=%h", iaddr, iload);
        @(negedge CLK);
    endtask

    task automatic test_async_reset();
        bit gi, gd;
        int n;
        ram_mode = 0; ram_wait = 0;
        iREN = 1'b1; iaddr = 32'h40;
        wait_hit(20, gi, gd, n);
        exp_iload = ref_mem[16];
        if (gi !== 1'b1 || iload !== exp_iload) begin
            errors++; $display("FAIL t5_prefetch: got ihit=%b iload=%h expected 1 %h", gi, iload, exp_iload);
        end
        checks++;
        iREN = 1'b0;
        @(negedge CLK);
        ram_mode = 1;
        iREN = 1'b1;
        @(negedge CLK);
        if (ramREN !== 1'b1) begin
            errors++; $display("FAIL t5_isvc: got ren=%b expected 1", ramREN);
        end
        checks++;
        #2 RST = 1'b1;
        #1;
        if ({ramREN, ihit} !== 2'b00 || iload !== 32'h0 || dload !== 32'h0) begin
            errors++;
            $display("FAIL t5_async: got ren/ihit=%b iload=%h dload=%h expected 00 0 0", {ramREN, ihit}, iload, dload);
        end
        checks++;
        @(negedge CLK);
        RST = 1'b0; iREN = 1'b0; ram_mode = 0;
        last_was_d = 1'b0;
        exp_iload = '0; exp_dload = '0;
        @(negedge CLK);
        if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
            errors++; $display("FAIL t5_idle: got %b expected 0000", {ramREN, ramWEN, ihit, dhit});
        end
        checks++;
        $display("txn reset mid-service");
        iREN = 1'b1; dREN = 1'b1;
        iaddr = 32'($urandom_range(0, 63) * 4);
        daddr = 32'($urandom_range(0, 63) * 4);
        wait_hit(20, gi, gd, n);
        exp_dload = ref_mem[daddr[7:2]];
        if ({gi, gd} !== 2'b01 || dload !== exp_dload) begin
            errors++;
            $display("FAIL t5_first_grant: got i/d=%b dload=%h expected 01 %h", {gi, gd}, dload, exp_dload);
        end
        checks++;
        dREN = 1'b0;
        @(negedge CLK);
        wait_hit(20, gi, gd, n);
        if ({gi, gd} !== 2'b10) begin
            errors++; $display("FAIL t5_second_grant: got i/d=%b expected 10", {gi, gd});
        end
        checks++;
        iREN = 1'b0;
        exp_iload = ref_mem[iaddr[7:2]];
        last_was_d = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        bit gi, gd, exp_d, pend_i, pend_d, wi;
        int n, dk, lat;
        ram_mode = 0;
        for (int it = 0; it < 30; it++) begin
            wi = 1'($urandom_range(0, 1));
            dk = $urandom_range(0, 3);
            if (!wi && dk == 0) wi = 1'b1;
            iaddr  = 32'($urandom_range(0, 63) * 4);
            daddr  = 32'($urandom_range(0, 63) * 4);
            dstore = $urandom;
            ram_wait = $urandom_range(0, 3);
            iREN = wi;
            dREN = (dk == 1 || dk == 3);
            dWEN = (dk >= 2);
            pend_i = wi;
            pend_d = (dk != 0);
            while (pend_i || pend_d) begin
                exp_d = pend_d && (!pend_i || !last_was_d);
                lat = 2 + ram_wait;
                wait_hit(30, gi, gd, n);
                if (n > 30) begin
                    errors++;
                    $display("FAIL rnd_timeout%0d: got no hit in 30 cycles expected %s hit", it, exp_d ? "D" : "I");
                    checks++;
                    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
                    pend_i = 1'b0; pend_d = 1'b0;
                end else begin
                    if ({gi, gd} !== {!exp_d, exp_d} || n != lat) begin
                        errors++;
                        $display("FAIL rnd_grant%0d: got i/d=%b lat=%0d expected %b lat=%0d", it, {gi, gd}, n, {!exp_d, exp_d}, lat);
                    end
                    checks++;
                    if (exp_d && dWEN) begin
                        ref_mem[daddr[7:2]] = dstore;
                        if (mem[daddr[7:2]] !== ref_mem[daddr[7:2]] || dload !== exp_dload) begin
                            errors++;
                            $display("FAIL rnd_write%0d: got ram=%h dload=%h expected ram=%h dload=%h",
                                     it, mem[daddr[7:2]], dload, ref_mem[daddr[7:2]], exp_dload);
                        end
                        $display("txn D write addr=%h data=%h", daddr, dstore);
                    end else if (exp_d) begin
                        exp_dload = ref_mem[daddr[7:2]];
                        if (dload !== exp_dload) begin
                            errors++; $display("FAIL rnd_dload%0d: got %h expected %h", it, dload, exp_dload);
                        end
                        $display("txn D read addr=%h data=%h", daddr, dload);
                    end else begin
                        exp_iload = ref_mem[iaddr[7:2]];
                        if (iload !== exp_iload) begin
                            errors++; $display("FAIL rnd_iload%0d: got %h expected %h", it, iload, exp_iload);
                        end
                        $display("txn I addr=%h data=%h", iaddr, iload);
                    end
                    checks++;
                    if (exp_d) begin
                        dREN = 1'b0; dWEN = 1'b0; pend_d = 1'b0;
                    end else begin
                        iREN = 1'b0; pend_i = 1'b0;
                    end
                    last_was_d = exp_d;
                    @(negedge CLK);
                    if ({ihit, dhit, arb_err} !== 3'b000) begin
                        errors++; $display("FAIL rnd_pulse%0d: got ih/dh/err=%b expected 000", it, {ihit, dhit, arb_err});
                    end
                    checks++;
                end
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        ram_mode = 1;
        dREN = 1'b1; daddr = 32'h10;
        n = 21;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (arb_err === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n != 9 || dhit !== 1'b0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL t6_timeout: got err_at=%0d dhit=%b ren=%b expected 9 0 0", n, dhit, ramREN);
        end
        checks++;
        dREN = 1'b0;
        ram_mode = 0;
        @(negedge CLK);
        if (arb_err !== 1'b0) begin
            errors++; $display("FAIL t6_pulse: got %b expected 0", arb_err);
        end
        checks++;
        $display("txn D watchdog abort");
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 32'h2108_0001;
        ref_mem[16] = 32'h2108_0001;
        exp_iload = '0;
        exp_dload = '0;
        test_reset();
        test_ifetch();
        test_priority();
        test_alternate();
        test_abort_error();
        test_async_reset();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish after 200000 ns expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
